ps2_key_tracker: RTL and testbench
==================================

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, depth of the held-key table (1..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, the CLOCK_50 cycles without a PS/2 falling edge before a partial frame is aborted.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flip-flop depth of the PS2_CLK/PS2_DAT synchronisers (min 2).
REQ-004 CLOCK_50  in  1  sole system clock; all state on its rising edge.
REQ-005 resetN  in  1  asynchronous, active-low reset.
REQ-006 PS2_CLK  in  1  raw PS/2 clock line, asynchronous, sampled only.
REQ-007 PS2_DAT  in  1  raw PS/2 data line, asynchronous, sampled only.
REQ-008 query_code  in  9  {ext, scancode} to look up in the held table.
REQ-009 query_held  out  1  combinational: query_code is in the held table.
REQ-010 evt_valid  out  1  one-cycle pulse: a complete key event decoded.
REQ-011 evt_code  out  8  scancode of the event; valid with evt_valid.
REQ-012 evt_ext  out  1  event was E0-prefixed.
REQ-013 evt_break  out  1  event is a release (F0-prefixed).
REQ-014 evt_repeat  out  1  make event for a key already held (typematic).
REQ-015 frame_err  out  1  one-cycle pulse: frame discarded (start, stop, parity or timeout).
REQ-016 overflow  out  1  one-cycle pulse: make of a new key with table full.
REQ-017 held_count  out  $clog2(N_KEYS+1)  number of valid held-table entries.
REQ-018 held_table  out  9*N_KEYS  entries {ext, code}; entry 0 oldest, in LSBs; invalid entries read 0.

Function
REQ-019 Inputs SHALL pass through SYNC_STAGES synchronisers; a PS/2 falling edge is synchronised PS2_CLK 1 then 0 on consecutive samples.
REQ-020 Receiver SHALL capture synchronised PS2_DAT at each falling edge into an 11-bit frame, LSB first: start, 8 data, parity, stop.
REQ-021 Frame valid only if start=0, stop=1 and data plus parity has an odd number of ones; otherwise frame_err pulses and the frame is dropped.
REQ-022 Bit counter SHALL be 0 when idle; a timeout SHALL be counted only while it is 1..10; reaching TIMEOUT_CYCLES pulses frame_err and returns the counter to 0.
REQ-023 Decoder FSM states: BASE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen).
REQ-024 Transitions on a valid byte: E0 in BASE->EXT; F0 in BASE->BRK; F0 in EXT->EXT_BRK; any other byte emits an event and returns to BASE.
REQ-025 E0 received in BRK or EXT_BRK, or E0 received in EXT, SHALL return to BASE with no event and no frame_err.
REQ-026 evt_valid SHALL pulse exactly 1 cycle after the cycle the stop-bit falling edge is detected; evt_* hold their values until the next event.
REQ-027 A frame_err or timeout SHALL also return the decoder to BASE, discarding any pending prefix.
REQ-028 On a make of an absent key with held_count<N_KEYS, the key SHALL be appended at index held_count and held_count incremented, in the evt_valid cycle.
REQ-029 On a make of a present key, evt_repeat=1 and the table SHALL be unchanged.
REQ-030 On a make of an absent key with the table full, overflow pulses with evt_valid and the table SHALL be unchanged.
REQ-031 On a break of a present key, that entry SHALL be removed, higher entries shifted down one and held_count decremented.
REQ-032 On a break of an absent key, the event SHALL still be emitted and the table unchanged.
REQ-033 Key identity SHALL be the 9-bit {ext, code}, so 0x14 and E0 0x14 are distinct keys.
REQ-034 Bytes 0x00 and 0xFF (error/overrun codes) SHALL be dropped with frame_err pulsed.

Reset
REQ-035 With resetN low: all outputs except query_held are 0, the FSM is in BASE, the bit and timeout counters are 0, the table is empty and the synchronisers hold 1 (line idle).
REQ-036 A reset in mid-frame SHALL discard the partial frame; reception restarts on the next start bit.

Structure
REQ-037 Package ps2_pkg SHALL hold the constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_FRAME_BITS=11, and the decoder-state enum.
REQ-038 Sub-module ps2_frame_rx SHALL contain the synchroniser, falling-edge detect, shift, checks and timeout, and present byte/byte_valid/frame_err to the tracker.

Verification
REQ-039 Send frames 0x29, then F0 0x29 -> make event (code 29, ext 0, break 0), held_count 1, then break event, held_count 0.
REQ-040 Send E0 0x75, then 0x75 -> two events (ext 1, then ext 0); held_table = {1,75},{0,75}; query_code 9'h175 -> query_held 1.
REQ-041 Send 0x1C with bad parity -> frame_err pulse, no evt_valid; then a clean 0x1C -> normal event.
REQ-042 Send start plus 4 bits, then idle for TIMEOUT_CYCLES -> frame_err pulse; the next full 0x29 decodes correctly.
REQ-043 With N_KEYS=4, make 5 distinct keys then repeat key 1 -> overflow on the 5th, evt_repeat on the repeat; break key 2 -> remaining entries compact in order.
REQ-044 Assert resetN low after 6 bits of a frame -> all outputs 0 and table empty; the next full frame decodes.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 constants, decoder states and frame check helper
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_BASE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_e;

  typedef logic [8:0] key_t;

  // Frame is {stop, parity, data[7:0], start}; data plus parity must hold an odd count of ones.
  function automatic logic frame_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && f[10] && (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 line synchroniser, falling-edge sampler, frame checker and timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;

  logic clk_s, dat_s, fall;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign dat_s  = dat_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;
  assign byte_o = shift_q[8:1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      to_cnt_q   <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev_q <= clk_s;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // The stop bit is checked straight off the line so the verdict lands in the edge cycle.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
        bit_cnt_d = '0;
        if (frame_ok({dat_s, shift_q})) byte_valid_o = 1'b1;
        else                            frame_err_o  = 1'b1;
      end else begin
        shift_d[bit_cnt_q] = dat_s;
        bit_cnt_d          = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        to_cnt_d    = '0;
        bit_cnt_d   = '0;
        frame_err_o = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 scancode decoder with an ordered table of currently held keys
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int N_KEYS         = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          resetN,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  input  logic [8:0]                    query_code,
  output logic                          query_held,
  output logic                          evt_valid,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic                          evt_repeat,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(N_KEYS+1)-1:0]   held_count,
  output logic [9*N_KEYS-1:0]           held_table
);

  localparam int CW = $clog2(N_KEYS + 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk_i       (CLOCK_50),
    .rst_ni      (resetN),
    .ps2_clk_i   (PS2_CLK),
    .ps2_dat_i   (PS2_DAT),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_err)
  );

  dec_state_e    state_q, state_d;
  key_t          tbl_q [N_KEYS];
  key_t          tbl_d [N_KEYS];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          evt_valid_q, evt_valid_d;
  logic [7:0]    evt_code_q, evt_code_d;
  logic          evt_ext_q, evt_ext_d;
  logic          evt_break_q, evt_break_d;
  logic          evt_repeat_q, evt_repeat_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;

  key_t          key;
  logic          is_ext, is_break;
  logic          hit;
  logic [CW-1:0] hit_idx;

  assign is_ext   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign is_break = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
  assign key      = {is_ext, rx_byte};

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (!hit && (CW'(i) < cnt_q) && (tbl_q[i] == key)) begin
        hit     = 1'b1;
        hit_idx = CW'(i);
      end
    end
  end

  always_comb begin
    query_held = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if ((CW'(i) < cnt_q) && (tbl_q[i] == query_code)) query_held = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < N_KEYS; i++) held_table[9*i +: 9] = tbl_q[i];
  end

  always_comb begin
    state_d      = state_q;
    tbl_d        = tbl_q;
    cnt_d        = cnt_q;
    evt_valid_d  = 1'b0;
    evt_code_d   = evt_code_q;
    evt_ext_d    = evt_ext_q;
    evt_break_d  = evt_break_q;
    evt_repeat_d = evt_repeat_q;
    frame_err_d  = 1'b0;
    overflow_d   = 1'b0;
    if (rx_err) begin
      frame_err_d = 1'b1;
      state_d     = ST_BASE;
    end else if (rx_valid) begin
      if (rx_byte == 8'h00 || rx_byte == 8'hFF) begin
        frame_err_d = 1'b1;
        state_d     = ST_BASE;
      end else if (rx_byte == PS2_EXT) begin
        // A second E0, or E0 after F0, is a broken prefix: start over quietly.
        state_d = (state_q == ST_BASE) ? ST_EXT : ST_BASE;
      end else if (rx_byte == PS2_BRK && state_q == ST_BASE) begin
        state_d = ST_BRK;
      end else if (rx_byte == PS2_BRK && state_q == ST_EXT) begin
        state_d = ST_EXT_BRK;
      end else begin
        state_d      = ST_BASE;
        evt_valid_d  = 1'b1;
        evt_code_d   = rx_byte;
        evt_ext_d    = is_ext;
        evt_break_d  = is_break;
        evt_repeat_d = !is_break && hit;
        if (is_break) begin
          if (hit) begin
            for (int i = 0; i < N_KEYS - 1; i++) begin
              if (CW'(i) >= hit_idx) tbl_d[i] = tbl_q[i+1];
            end
            tbl_d[N_KEYS-1] = '0;
            cnt_d           = cnt_q - 1'b1;
          end
        end else if (!hit) begin
          if (cnt_q < CW'(N_KEYS)) begin
            for (int i = 0; i < N_KEYS; i++) begin
              if (CW'(i) == cnt_q) tbl_d[i] = key;
            end
            cnt_d = cnt_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_BASE;
      for (int i = 0; i < N_KEYS; i++) tbl_q[i] <= '0;
      cnt_q        <= '0;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= '0;
      evt_ext_q    <= 1'b0;
      evt_break_q  <= 1'b0;
      evt_repeat_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      for (int i = 0; i < N_KEYS; i++) tbl_q[i] <= tbl_d[i];
      cnt_q        <= cnt_d;
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
      evt_ext_q    <= evt_ext_d;
      evt_break_q  <= evt_break_d;
      evt_repeat_q <= evt_repeat_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_code   = evt_code_q;
  assign evt_ext    = evt_ext_q;
  assign evt_break  = evt_break_q;
  assign evt_repeat = evt_repeat_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign held_count = cnt_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - self-checking bench for ps2_key_tracker
module tb_ps2_key_tracker;

  localparam int N_KEYS = 4;
  localparam int TO     = 200;
  localparam int HALF   = 20;

  logic        CLOCK_50 = 1'b0;
  logic        resetN   = 1'b0;
  logic        PS2_CLK  = 1'b1;
  logic        PS2_DAT  = 1'b1;
  logic [8:0]  query_code = '0;
  logic        query_held, evt_valid, evt_ext, evt_break, evt_repeat, frame_err, overflow;
  logic [7:0]  evt_code;
  logic [2:0]  held_count;
  logic [35:0] held_table;

  ps2_key_tracker #(.N_KEYS(N_KEYS), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .CLOCK_50(CLOCK_50), .resetN(resetN), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .query_code(query_code), .query_held(query_held), .evt_valid(evt_valid),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break), .evt_repeat(evt_repeat),
    .frame_err(frame_err), .overflow(overflow), .held_count(held_count), .held_table(held_table)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [7:0] code;
    logic       ext, brk, rep, ovf;
    logic [2:0] cnt;
  } evt_t;

  typedef struct {
    logic [7:0] d;
    logic       bp, bs, ev, fe;
    evt_t       e;
  } vec_t;

  evt_t exp_q[$];
  evt_t obs_q[$];
  vec_t vecs[$];
  int   ferr_seen = 0;
  int   ferr_exp  = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(negedge CLOCK_50) begin
    if (evt_valid) obs_q.push_back({evt_code, evt_ext, evt_break, evt_repeat, overflow, held_count});
    if (frame_err) ferr_seen++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      PS2_DAT = f[i];
      repeat (HALF) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    repeat (HALF) @(negedge CLOCK_50);
  endtask

  task automatic drain(input string name);
    check({name, " frame_err count"}, 64'(ferr_seen), 64'(ferr_exp));
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL %s unexpected event: got %0h expected none", name, obs_q.pop_front());
      end else if (obs_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL %s missing event: got none expected %0h", name, exp_q.pop_front());
      end else begin
        check({name, " event"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic ap(input logic [7:0] d);
    vecs.push_back('{d: d, bp: 1'b0, bs: 1'b0, ev: 1'b0, fe: 1'b0, e: '0});
  endtask

  task automatic af(input logic [7:0] d, input logic bp, input logic bs);
    vecs.push_back('{d: d, bp: bp, bs: bs, ev: 1'b0, fe: 1'b1, e: '0});
  endtask

  task automatic ae(input logic [7:0] d, input logic x, input logic b, input logic r,
                    input logic o, input logic [2:0] n);
    vecs.push_back('{d: d, bp: 1'b0, bs: 1'b0, ev: 1'b1, fe: 1'b0, e: {d, x, b, r, o, n}});
  endtask

  task automatic query(input logic [8:0] q, input logic exp);
    query_code = q;
    @(negedge CLOCK_50);
    check($sformatf("query_held %0h", q), 64'(query_held), 64'(exp));
  endtask

  initial begin
    repeat (3) @(negedge CLOCK_50);
    check("reset outputs",
          {evt_valid, evt_code, evt_ext, evt_break, evt_repeat, frame_err, overflow, held_count, held_table},
          '0);
    resetN = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    ae(8'h29, 0, 0, 0, 0, 1); ap(8'hF0); ae(8'h29, 0, 1, 0, 0, 0);
    ap(8'hE0); ae(8'h75, 1, 0, 0, 0, 1); ae(8'h75, 0, 0, 0, 0, 2);
    ap(8'hE0); ap(8'hF0); ae(8'h75, 1, 1, 0, 0, 1); ap(8'hF0); ae(8'h75, 0, 1, 0, 0, 0);
    af(8'h1C, 1, 0); ae(8'h1C, 0, 0, 0, 0, 1); ap(8'hF0); ae(8'h1C, 0, 1, 0, 0, 0);
    af(8'h00, 0, 0); af(8'hFF, 0, 0); af(8'h29, 0, 1);
    ap(8'hE0); ap(8'hE0); ae(8'h14, 0, 0, 0, 0, 1);
    ap(8'hF0); ap(8'hE0); ae(8'h14, 0, 0, 1, 0, 1);
    ap(8'hF0); ae(8'h14, 0, 1, 0, 0, 0);
    ae(8'h15, 0, 0, 0, 0, 1); ae(8'h16, 0, 0, 0, 0, 2); ap(8'hE0); ae(8'h17, 1, 0, 0, 0, 3);
    ae(8'h18, 0, 0, 0, 0, 4); ae(8'h19, 0, 0, 0, 1, 4); ae(8'h15, 0, 0, 1, 0, 4);
    ap(8'hF0); ae(8'h16, 0, 1, 0, 0, 3);
    ap(8'hF0); ae(8'h15, 0, 1, 0, 0, 2); ap(8'hE0); ap(8'hF0); ae(8'h17, 1, 1, 0, 0, 1);
    ap(8'hF0); ae(8'h18, 0, 1, 0, 0, 0); ap(8'hF0); ae(8'h19, 0, 1, 0, 0, 0);
    ap(8'hE0); af(8'h1C, 1, 0); ae(8'h1C, 0, 0, 0, 0, 1); ap(8'hF0); ae(8'h1C, 0, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].ev) exp_q.push_back(vecs[i].e);
      if (vecs[i].fe) ferr_exp++;
      send_bits(mk(vecs[i].d, vecs[i].bp, vecs[i].bs), 11);
      drain($sformatf("vec%0d", i));
      if (i == 5) begin
        check("table after E0 75, 75", 64'(held_table), 64'({9'h000, 9'h000, 9'h075, 9'h175}));
        query(9'h175, 1'b1);
        query(9'h075, 1'b1);
        query(9'h014, 1'b0);
      end
      if (i == 34) begin
        check("table after break 16", 64'(held_table), 64'({9'h000, 9'h018, 9'h117, 9'h015}));
        query(9'h016, 1'b0);
        query(9'h117, 1'b1);
      end
    end

    // Timeout mid-frame also discards a pending E0 prefix.
    send_bits(mk(8'hE0, 0, 0), 11);
    send_bits(mk(8'h29, 0, 0), 5);
    repeat (TO + 40) @(negedge CLOCK_50);
    ferr_exp++;
    drain("timeout");
    exp_q.push_back({8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1});
    send_bits(mk(8'h29, 0, 0), 11);
    drain("after timeout");

    // Reset after 6 bits: table (holding 29) and event outputs must clear.
    send_bits(mk(8'h33, 0, 0), 6);
    resetN = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("mid-frame reset outputs",
          {evt_valid, evt_code, evt_ext, evt_break, evt_repeat, frame_err, overflow, held_count, held_table},
          '0);
    resetN = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    exp_q.push_back({8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1});
    send_bits(mk(8'h29, 0, 0), 11);
    drain("after reset");
    check("table after reset", 64'(held_table), 64'({27'h0, 9'h029}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
